// File: rtl/input_debounce_if.sv
// ---------------------------------------------------------------------------
// input_debounce_if
//   Bundle between the board-side raw button/switch lines and the application
//   logic that consumes the cleaned-up versions.
//
//   raw_i      active-high raw inputs (asynchronous, may bounce)
//   level_o    debounced level per bit
//   press_o    one-cycle pulse on debounced 0->1
//   release_o  one-cycle pulse on debounced 1->0
//   repeat_o   one-cycle auto-repeat pulse while a bit is held high
//
//   master : the side that supplies raw_i and consumes the results
//   slave  : the debouncer itself
// ---------------------------------------------------------------------------
interface input_debounce_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] raw_i;
   logic [WIDTH-1:0] level_o;
   logic [WIDTH-1:0] press_o;
   logic [WIDTH-1:0] release_o;
   logic [WIDTH-1:0] repeat_o;

   modport master (
      output raw_i,
      input  level_o,
      input  press_o,
      input  release_o,
      input  repeat_o
   );

   modport slave (
      input  raw_i,
      output level_o,
      output press_o,
      output release_o,
      output repeat_o
   );
endinterface

// File: rtl/input_debounce.sv
// ---------------------------------------------------------------------------
// input_debounce
//   Per-bit synchroniser + debouncer + edge pulses + auto-repeat for the
//   board's buttons and switches. Every bit is an independent copy of the
//   same logic; there is no interaction between bits.
//
//   clk_i  system clock (single domain)
//   rst_i  synchronous, active-high reset
//   bus    input_debounce_if.slave: raw_i in; level_o, press_o, release_o,
//          repeat_o out
//
//   Parameters:
//   WIDTH            number of input bits
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before the level flips (>=1)
//   REPEAT_DELAY     cycles from press pulse to first repeat pulse (0 = off)
//   REPEAT_PERIOD    cycles between later repeat pulses (>=1)
// ---------------------------------------------------------------------------
module input_debounce #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int REPEAT_DELAY    = 13500000,
   parameter int REPEAT_PERIOD   = 2700000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input_debounce_if.slave bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX + 1);
   localparam logic [RP_W-1:0] RP_DELAY_C  = RP_W'(REPEAT_DELAY);
   localparam logic [RP_W-1:0] RP_PERIOD_C = RP_W'(REPEAT_PERIOD);

   // Repeat phase encoding
   localparam logic [0:0] PH_DELAY  = 1'b0;
   localparam logic [0:0] PH_PERIOD = 1'b1;

   logic [WIDTH-1:0] level_vec;
   logic [WIDTH-1:0] press_vec;
   logic [WIDTH-1:0] release_vec;
   logic [WIDTH-1:0] repeat_vec;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            press_reg;
      logic            release_reg;
      logic [DB_W-1:0] db_cnt_reg;
      logic            flip;
      logic            rise;
      logic            fall;

      // The level flips on the edge where the disagreement has lasted the
      // full debounce window; press/release are registered on that same
      // edge so they line up with the new level_o value.
      assign flip = (sync2_reg != level_reg) && (db_cnt_reg == DB_LAST);
      assign rise = flip && sync2_reg;
      assign fall = flip && !sync2_reg;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            db_cnt_reg  <= '0;
         end else begin
            sync1_reg   <= bus.raw_i[gi];
            sync2_reg   <= sync1_reg;
            press_reg   <= rise;
            release_reg <= fall;
            if (sync2_reg == level_reg) begin
               db_cnt_reg <= '0;
            end else if (flip) begin
               level_reg  <= sync2_reg;
               db_cnt_reg <= '0;
            end else begin
               db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end
         end
      end

      assign level_vec[gi]   = level_reg;
      assign press_vec[gi]   = press_reg;
      assign release_vec[gi] = release_reg;

      if (REPEAT_DELAY > 0) begin : g_rep
         logic [RP_W-1:0] rp_cnt_reg;
         logic [0:0]      phase_reg;
         logic            repeat_reg;

         // The counter is loaded with 1 on the press edge, so reaching the
         // compare value N means exactly N cycles have elapsed since the
         // press (or since the previous repeat pulse).
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rp_cnt_reg <= '0;
               phase_reg  <= PH_DELAY;
               repeat_reg <= 1'b0;
            end else if (rise) begin
               rp_cnt_reg <= RP_W'(1);
               phase_reg  <= PH_DELAY;
               repeat_reg <= 1'b0;
            end else if (fall || !level_reg) begin
               rp_cnt_reg <= '0;
               phase_reg  <= PH_DELAY;
               repeat_reg <= 1'b0;
            end else if (phase_reg == PH_DELAY && rp_cnt_reg == RP_DELAY_C) begin
               rp_cnt_reg <= RP_W'(1);
               phase_reg  <= PH_PERIOD;
               repeat_reg <= 1'b1;
            end else if (phase_reg == PH_PERIOD && rp_cnt_reg == RP_PERIOD_C) begin
               rp_cnt_reg <= RP_W'(1);
               repeat_reg <= 1'b1;
            end else begin
               rp_cnt_reg <= rp_cnt_reg + RP_W'(1);
               repeat_reg <= 1'b0;
            end
         end

         assign repeat_vec[gi] = repeat_reg;
      end else begin : g_norep
         assign repeat_vec[gi] = 1'b0;
      end
   end

   assign bus.level_o   = level_vec;
   assign bus.press_o   = press_vec;
   assign bus.release_o = release_vec;
   assign bus.repeat_o  = repeat_vec;

endmodule

// File: tb/tb_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_input_debounce
//   Self-checking bench for input_debounce with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3, WIDTH=8. Directed scenarios check the
//   hand-derived timing; every cycle is also compared against a reference
//   model that reasons on a window of recent synchronised samples and on the
//   elapsed time since each press.
// ---------------------------------------------------------------------------
module tb_input_debounce;
   localparam int WIDTH = 8;
   localparam int DB    = 4;
   localparam int RD    = 10;
   localparam int RP    = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] raw = '0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   input_debounce_if #(.WIDTH(WIDTH)) bus ();
   assign bus.raw_i = raw;

   input_debounce #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_rep;
   logic [WIDTH-1:0] hist [DB];   // hist[0] = newest synchronised sample
   int               press_cyc [WIDTH];

   task automatic model_edge();
      logic [WIDTH-1:0] s2_before;
      logic             all_diff;
      int               k;
      s2_before = m_s2;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_level = '0;
         m_press = '0; m_rel = '0; m_rep = '0;
         for (int i = 0; i < DB; i++) hist[i] = '0;
         for (int b = 0; b < WIDTH; b++) press_cyc[b] = 0;
      end else begin
         for (int i = DB - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = s2_before;
         m_s2 = m_s1;
         m_s1 = raw;
         for (int b = 0; b < WIDTH; b++) begin
            m_press[b] = 1'b0; m_rel[b] = 1'b0; m_rep[b] = 1'b0;
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++)
               if (hist[i][b] == m_level[b]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[b] = ~m_level[b];
               if (m_level[b]) begin
                  m_press[b]   = 1'b1;
                  press_cyc[b] = cyc;
               end else begin
                  m_rel[b] = 1'b1;
               end
            end else if (m_level[b]) begin
               k = cyc - press_cyc[b];
               m_rep[b] = (k == RD) || (k > RD && ((k - RD) % RP) == 0);
            end
         end
      end
   endtask

   function automatic logic [4*WIDTH-1:0] model_out();
      return {m_level, m_press, m_rel, m_rep};
   endfunction

   function automatic logic [4*WIDTH-1:0] dut_out();
      return {bus.level_o, bus.press_o, bus.release_o, bus.repeat_o};
   endfunction

   // One clock edge: model follows the inputs applied before the edge,
   // outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      raw = '0;
      tick();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      raw = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++;
         if (dut_out() !== '0) begin
            n_fail++;
            $display("FAIL reset cyc=%0d got=%h exp=0", cyc, dut_out());
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_step();
      apply_reset();
      raw[0] = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_tests++;
         if ({bus.level_o[0], bus.press_o[0]} !== {1'(e >= 6), 1'(e == 6)}) begin
            n_fail++;
            $display("FAIL step_rise e=%0d got l/p=%b%b exp %b%b", e,
                     bus.level_o[0], bus.press_o[0], e >= 6, e == 6);
         end
         n_tests++;
         if (dut_out() !== model_out()) begin
            n_fail++;
            $display("FAIL step_model cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
         end
      end
      raw[0] = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_tests++;
         if ({bus.level_o[0], bus.release_o[0]} !== {1'(e < 6), 1'(e == 6)}) begin
            n_fail++;
            $display("FAIL step_fall e=%0d got l/r=%b%b exp %b%b", e,
                     bus.level_o[0], bus.release_o[0], e < 6, e == 6);
         end
      end
   endtask

   task automatic test_bounce();
      int seq [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
      int presses = 0;
      apply_reset();
      for (int e = 1; e <= 17; e++) begin
         raw[1] = (e <= 9) ? 1'(seq[e-1]) : 1'b1;
         tick();
         if (bus.press_o[1]) presses++;
         n_tests++;
         if (bus.level_o[1] !== 1'(e >= 11)) begin
            n_fail++;
            $display("FAIL bounce_level e=%0d got=%b exp=%b", e, bus.level_o[1], e >= 11);
         end
         n_tests++;
         if (dut_out() !== model_out()) begin
            n_fail++;
            $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
         end
      end
      n_tests++;
      if (presses != 1) begin
         n_fail++;
         $display("FAIL bounce_presses got=%0d exp=1", presses);
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      for (int e = 1; e <= 13; e++) begin
         raw[2] = (e <= 3);
         tick();
         n_tests++;
         if ({bus.level_o[2], bus.press_o[2], bus.release_o[2]} !== 3'b000) begin
            n_fail++;
            $display("FAIL glitch e=%0d got l/p/r=%b%b%b exp 000", e,
                     bus.level_o[2], bus.press_o[2], bus.release_o[2]);
         end
      end
   endtask

   task automatic test_repeat();
      int rel_seen = 0;
      int rep_after = 0;
      bit released = 0;
      apply_reset();
      raw[3] = 1'b1;
      for (int e = 1; e <= 6; e++) tick();
      n_tests++;
      if (bus.press_o[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL repeat_press got=%b exp=1", bus.press_o[3]);
      end
      for (int k = 1; k <= 17; k++) begin
         tick();
         n_tests++;
         if (bus.repeat_o[3] !== 1'(k == 10 || k == 13 || k == 16)) begin
            n_fail++;
            $display("FAIL repeat_timing k=%0d got=%b exp=%b", k, bus.repeat_o[3],
                     k == 10 || k == 13 || k == 16);
         end
         n_tests++;
         if (dut_out() !== model_out()) begin
            n_fail++;
            $display("FAIL repeat_model cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
         end
      end
      raw[3] = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (released && bus.repeat_o[3]) rep_after++;
         if (bus.release_o[3]) begin
            rel_seen++;
            released = 1;
            n_tests++;
            if (bus.repeat_o[3] !== 1'b0) begin
               n_fail++;
               $display("FAIL repeat_on_release got=%b exp=0", bus.repeat_o[3]);
            end
         end
         n_tests++;
         if (dut_out() !== model_out()) begin
            n_fail++;
            $display("FAIL repeat_model cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
         end
      end
      n_tests++;
      if (rel_seen != 1 || rep_after != 0) begin
         n_fail++;
         $display("FAIL repeat_release got rel=%0d rep=%0d exp rel=1 rep=0", rel_seen, rep_after);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      raw[3] = 1'b1;
      for (int e = 1; e <= 17; e++) tick();   // bit 3 pressed at edge 6, now mid-repeat
      raw[4] = 1'b1;
      for (int e = 1; e <= 4; e++) tick();    // bit 4 debounce counter at 2
      n_tests++;
      if (dut_out() !== model_out()) begin
         n_fail++;
         $display("FAIL midreset_pre cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (dut_out() !== '0) begin
         n_fail++;
         $display("FAIL midreset_clear got=%h exp=0", dut_out());
      end
      for (int e = 1; e <= 17; e++) begin
         tick();
         n_tests++;
         if ({bus.press_o[4:3], bus.repeat_o[4:3]} !== {{2{1'(e == 6)}}, {2{1'(e == 16)}}}) begin
            n_fail++;
            $display("FAIL midreset_timing e=%0d got p=%b rp=%b exp p=%b rp=%b", e,
                     bus.press_o[4:3], bus.repeat_o[4:3], {2{1'(e == 6)}}, {2{1'(e == 16)}});
         end
         n_tests++;
         if (dut_out() !== model_out()) begin
            n_fail++;
            $display("FAIL midreset_model cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
         end
      end
   endtask

   task automatic test_two_bits();
      apply_reset();
      raw[0] = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         if (e == 3) raw[7] = 1'b1;
         tick();
         n_tests++;
         if ({bus.level_o[7], bus.level_o[0], bus.press_o[7], bus.press_o[0]} !==
             {1'(e >= 8), 1'(e >= 6), 1'(e == 8), 1'(e == 6)}) begin
            n_fail++;
            $display("FAIL two_bits e=%0d got l7/l0/p7/p0=%b%b%b%b exp %b%b%b%b", e,
                     bus.level_o[7], bus.level_o[0], bus.press_o[7], bus.press_o[0],
                     e >= 8, e >= 6, e == 8, e == 6);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < WIDTH; b++)
            if ($urandom_range(0, 7) == 0) raw[b] = ~raw[b];
         rst = ($urandom_range(0, 249) == 0);
         tick();
         n_tests++;
         if (dut_out() !== model_out()) begin
            n_fail++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_step();
      test_bounce();
      test_glitch();
      test_repeat();
      test_reset_mid();
      test_two_bits();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Input-side companion to the LED/seven-segment output path.
- Takes the board's button and switch lines after top-level polarity inversion (active-high, asynchronous to clk_i) and does three things:
  - synchronises and debounces each bit;
  - produces clean levels plus one-cycle press/release pulses;
  - generates auto-repeat pulses while a bit is held.
- Sits between the board top and the application logic that consumes buttons/switches.

Parameters:
- WIDTH, 8, number of input bits (4 buttons + 4 switches).
- DEBOUNCE_CYCLES, 270000, consecutive clk_i cycles a synchronised input must differ from the debounced level before the level flips (10 ms at 27 MHz). Must be >= 1.
- REPEAT_DELAY, 13500000, cycles from a press pulse to the first repeat pulse (0.5 s). 0 disables repeat entirely.
- REPEAT_PERIOD, 2700000, cycles between consecutive repeat pulses after the first (0.1 s). Must be >= 1.

Ports:
- clk_i  input  1  system clock; single clock domain.
- rst_i  input  1  synchronous, active-high reset.
- raw_i  input  WIDTH  active-high raw inputs, asynchronous, may bounce.
- level_o  output  WIDTH  debounced level per bit.
- press_o  output  WIDTH  one-cycle pulse on debounced 0->1.
- release_o  output  WIDTH  one-cycle pulse on debounced 1->0.
- repeat_o  output  WIDTH  one-cycle pulse per auto-repeat tick while level_o bit is held high.

Behaviour:
- All state is per bit and fully independent; no cross-bit interaction.
- Reset (rst_i high at a clk_i edge) clears the following to 0: both synchroniser flops, debounce counter, level_o, press_o, release_o, repeat_o, repeat counter and the repeat phase flag.
  - Reset mid-debounce or mid-repeat discards all progress.
  - If raw_i is held high through reset, a press pulse is emitted after full debounce latency once reset deasserts.
- Synchroniser: 2 flops, sync1 <= raw_i, sync2 <= sync1.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: level <= sync2, counter <= 0.
  - Else: counter <= counter + 1.
  - A disagreement lasting fewer than DEBOUNCE_CYCLES consecutive sync2 cycles changes nothing; any agreeing cycle restarts the count.
- Latency: a clean step on raw_i, applied before edge 1, appears on level_o after edge DEBOUNCE_CYCLES+2.
- press_o / release_o:
  - Registered, asserted in exactly the same cycle level_o first shows the new value, for one cycle only.
  - press_o and release_o are never high together for the same bit.
- Repeat (only when REPEAT_DELAY > 0): per-bit counter of width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1) plus a phase flag (DELAY/PERIOD).
  - On the press cycle: counter <= 1, phase <= DELAY.
  - While level is high:
    - In DELAY phase, when counter == REPEAT_DELAY: repeat pulse, counter <= 1, phase <= PERIOD.
    - In PERIOD phase, when counter == REPEAT_PERIOD: repeat pulse, counter <= 1.
    - Otherwise: counter increments.
  - Timing: press pulse at cycle t gives repeats at t+REPEAT_DELAY, t+REPEAT_DELAY+REPEAT_PERIOD, and so on.
  - Release cycle (or level low): counter <= 0, phase <= DELAY, no repeat pulse. repeat_o is never high in a release_o cycle.
  - repeat_o and press_o are never high together for the same bit.
- REPEAT_DELAY == 0: repeat_o is tied to 0 and the repeat counters are optimised out.
- Counter wrap: counters never wrap; they are bounded by the compare values above.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, WIDTH=8):
- Reset, raw_i=0 -> all outputs 0. raw_i[0] steps 0->1 before edge 1 -> level_o[0]=1 and press_o[0]=1 after edge 6; press_o[0] back to 0 after edge 7.
- raw_i[1] bounces 1,0,1,1,0,1,1,1,1 (one value per cycle, then held 1) -> no change during the bounce; level_o[1] rises only after 4 consecutive sync2 highs, with one press pulse.
- raw_i[2] pulses high for 3 cycles, then returns to 0 -> level_o[2], press_o[2] and release_o[2] stay 0 throughout.
- Hold raw_i[3] high with press pulse at cycle t -> repeat_o[3] pulses at t+10, t+13, t+16. Drop raw_i[3] -> release_o[3] one cycle, no further repeat pulses.
- Assert rst_i for 1 cycle while bit 4 is mid-debounce (counter=2) and bit 3 is mid-repeat -> all outputs 0 next cycle. Bit 4, still high, presses 6 cycles after reset release. Repeat timing restarts from that new press.
- Drive bits 0 and 7 with different step times simultaneously -> each bit's level/press timing matches the single-bit case independently.
